// File: rtl/svfloat_pkg.sv
// Shared types and limits for the svfloat fixed/float conversion blocks.
//
// Contents:
//   fixed_accum_state_t         - block accumulator FSM states
//   FIXED_ACCUM_MAX_DEPTH_LOG2  - largest supported block length exponent
package svfloat;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } fixed_accum_state_t;

  localparam int unsigned FIXED_ACCUM_MAX_DEPTH_LOG2 = 8;

  // Number of bits needed to hold a sample count of 0..2^depth_log2.
  function automatic int unsigned fixed_accum_cnt_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/fixed_accum_sat_narrow.sv
// sat_narrow: combinational saturating narrowing of an in_width-bit value
// to out_width bits.
//
// Ports:
//   in        [in_width-1:0]   wide value (two's complement when issigned)
//   issigned                   interpret in/out as signed
//   out       [out_width-1:0]  clipped value
//   sat                        1 when clipping occurred
module sat_narrow #(
  parameter int unsigned in_width  = 34,
  parameter int unsigned out_width = 32
) (
  input  logic [in_width-1:0]  in,
  input  logic                 issigned,
  output logic [out_width-1:0] out,
  output logic                 sat
);

  localparam logic [out_width-1:0] UMax = '1;
  localparam logic [out_width-1:0] SMin = out_width'(1) << (out_width - 1);
  localparam logic [out_width-1:0] SMax = ~SMin;

  if (in_width > out_width) begin : g_narrow
    localparam int unsigned ExtW = in_width - out_width;

    logic [ExtW-1:0] upper;
    logic            fits_signed;
    logic            fits_unsigned;

    assign upper = in[in_width-1:out_width];
    // Signed value fits when every dropped bit equals the new sign bit.
    assign fits_signed   = (upper == {ExtW{in[out_width-1]}});
    assign fits_unsigned = (upper == '0);

    always_comb begin
      out = in[out_width-1:0];
      sat = 1'b0;
      if (issigned) begin
        if (!fits_signed) begin
          sat = 1'b1;
          out = in[in_width-1] ? SMin : SMax;
        end
      end else if (!fits_unsigned) begin
        sat = 1'b1;
        out = UMax;
      end
    end
  end else begin : g_pass
    // Equal widths: nothing can be clipped.
    assign out = in[out_width-1:0];
    assign sat = 1'b0;
  end

endmodule

// File: rtl/fixed_accum.sv
// fixed_accum: sums blocks of 2^depth_log2 fixed-point samples from a
// valid/ready stream and presents one result word per block, ready to feed
// itof (out -> in, out_issigned -> issigned).
//
// Build option: FIXED_ACCUM_AVG_EN - when defined, out is the block mean
// (sum shifted right by depth_log2, floor) and out_sat is tied to 0; when
// undefined, out is the raw sum saturated to width bits.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   clear                   synchronous flush of the current block
//   in_valid/in_ready/in    sample stream
//   issigned                sample signedness, latched on a block's first accept
//   out_valid/out_ready     result handshake
//   out, out_issigned       result word and its signedness
//   out_sat                 result was clipped
module fixed_accum
  import svfloat::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned frac       = 0,
  parameter int unsigned depth_log2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in,
  input  logic             issigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out,
  output logic             out_issigned,
  output logic             out_sat
);

  localparam int unsigned AccW = width + depth_log2;
  localparam int unsigned CntW = fixed_accum_cnt_width(depth_log2);
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << depth_log2) - 1);

  if (depth_log2 > FIXED_ACCUM_MAX_DEPTH_LOG2) begin : g_bad_depth
    $error("fixed_accum: depth_log2 exceeds FIXED_ACCUM_MAX_DEPTH_LOG2");
  end
  if (frac > width) begin : g_bad_frac
    $error("fixed_accum: frac exceeds width");
  end

  fixed_accum_state_t state_q, state_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               sgn_q, sgn_d;

  logic               accept;
  logic               ext_sgn;
  logic [AccW-1:0]    in_ext;

  assign accept = in_valid & in_ready;

  // On a block's first accept the fresh issigned decides the extension,
  // since it is only being latched that cycle.
  assign ext_sgn = (state_q == IDLE) ? issigned : sgn_q;

  if (depth_log2 > 0) begin : g_ext
    assign in_ext = {{depth_log2{ext_sgn & in[width-1]}}, in};
  end else begin : g_noext
    assign in_ext = in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = in_ext;
            cnt_d   = CntW'(1);
            sgn_d   = issigned;
            state_d = (depth_log2 == 0) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = acc_q + in_ext;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_issigned = sgn_q;

`ifdef FIXED_ACCUM_AVG_EN
  logic [AccW-1:0] mean;

  // Arithmetic shift floors signed sums; the mean always fits in width bits.
  always_comb begin
    if (sgn_q) begin
      mean = AccW'($signed(acc_q) >>> depth_log2);
    end else begin
      mean = acc_q >> depth_log2;
    end
  end

  assign out     = mean[width-1:0];
  assign out_sat = 1'b0;
`else
  sat_narrow #(
    .in_width (AccW),
    .out_width(width)
  ) u_sat_narrow (
    .in      (acc_q),
    .issigned(sgn_q),
    .out     (out),
    .sat     (out_sat)
  );
`endif

endmodule

// File: tb/tb_fixed_accum.sv
// Directed self-checking bench for fixed_accum with width=8, depth_log2=2.
module tb_fixed_accum;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in;
  logic         issigned;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_issigned;
  logic         out_sat;

  int n_total = 0;
  int n_pass  = 0;

`ifdef FIXED_ACCUM_AVG_EN
  localparam logic [W-1:0] ExpA = 8'd100, ExpB = 8'd103, ExpC = 8'hFE, ExpD = 8'h80;
  localparam logic [W-1:0] ExpE = 8'd2, ExpOnes = 8'd1;
  localparam logic SatA = 1'b0, SatB = 1'b0, SatD = 1'b0;
`else
  localparam logic [W-1:0] ExpA = 8'h7F, ExpB = 8'hFF, ExpC = 8'hFB, ExpD = 8'h80;
  localparam logic [W-1:0] ExpE = 8'd10, ExpOnes = 8'd4;
  localparam logic SatA = 1'b1, SatB = 1'b1, SatD = 1'b1;
`endif

  fixed_accum #(
    .width     (W),
    .frac      (0),
    .depth_log2(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in          (in),
    .issigned    (issigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .out_issigned(out_issigned),
    .out_sat     (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic s);
    in_valid = 1'b1;
    in       = d;
    issigned = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3, input logic s);
    send(d0, s);
    send(d1, s);
    send(d2, s);
    send(d3, s);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in        = '0;
    issigned  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_issigned", out_issigned, 0);
    step();
    rst_n = 1'b1;
    step();

    // Signed 100 x4: valid only after the 4th accept.
    send(8'd100, 1'b1);
    send(8'd100, 1'b1);
    send(8'd100, 1'b1);
    check("a_valid_early", out_valid, 0);
    check("a_ready_early", in_ready, 1);
    send(8'd100, 1'b1);
    check("a_valid", out_valid, 1);
    check("a_in_ready", in_ready, 0);
    check("a_out", out, ExpA);
    check("a_sat", out_sat, SatA);
    check("a_issigned", out_issigned, 1);
    drain();
    check("a_done", out_valid, 0);

    // Unsigned 200, 200, 10, 5.
    send4(8'd200, 8'd200, 8'd10, 8'd5, 1'b0);
    check("b_out", out, ExpB);
    check("b_sat", out_sat, SatB);
    check("b_issigned", out_issigned, 0);
    drain();

    // Signed -3, -2, 0, 0.
    send4(8'hFD, 8'hFE, 8'h00, 8'h00, 1'b1);
    check("c_out", out, ExpC);
    check("c_sat", out_sat, 0);
    drain();

    // Signed -128 x4.
    send4(8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
    check("d_out", out, ExpD);
    check("d_sat", out_sat, SatD);
    drain();

    // Backpressure in HOLD with in_valid held high.
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    in_valid = 1'b1;
    in       = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, ExpE);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Clear mid-block, with a sample presented in the clear cycle.
    send(8'd50, 1'b1);
    send(8'd50, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in       = 8'd50;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_ready", in_ready, 1);
    check("clr_valid", out_valid, 0);
    send(8'd1, 1'b1);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    check("clr_out", out, ExpOnes);
    check("clr_sat", out_sat, 0);
    check("clr_issigned", out_issigned, 1);

    // Clear while holding a result withdraws out_valid.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_hold_valid", out_valid, 0);
    check("clr_hold_ready", in_ready, 1);

    // Reset during HOLD acts immediately.
    send4(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
    check("rh_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rh_valid", out_valid, 0);
    check("rh_ready", in_ready, 1);
    check("rh_out", out, 0);
    step();
    rst_n = 1'b1;
    step();
    send4(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    check("rh_fresh_out", out, ExpOnes);
    check("rh_fresh_valid", out_valid, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
